// File: rtl/unidade_controle_jogada_pkg.sv
// unidade_controle_jogada_pkg: state codes shared by the memory-game control unit
package unidade_controle_jogada_pkg;
  typedef enum logic [3:0] {
    INICIAL  = 4'h0,
    PREPARA  = 4'h1,
    ESPERA   = 4'h2,
    REGISTRA = 4'h4,
    COMPARA  = 4'h5,
    PROXIMO  = 4'h6,
    FIM_OK   = 4'hA,
    FIM_TMO  = 4'hD,
    FIM_ERRO = 4'hE
  } estado_t;
endpackage

// File: rtl/unidade_controle_jogada_contador_timeout.sv
// contador_timeout: counts clocks while conta is high, flags the last count of M
module contador_timeout #(
  parameter int M = 3000
) (
  input  logic clock,
  input  logic zera,
  input  logic conta,
  output logic fim
);
  localparam int W = M > 1 ? $clog2(M) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = zera ? '0 : conta ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clock) cnt_q <= cnt_d;
  assign fim = cnt_q == W'(M - 1);
endmodule

// File: rtl/unidade_controle_jogada.sv
// unidade_controle_jogada: Moore FSM sequencing move capture, compare and round end
module unidade_controle_jogada
  import unidade_controle_jogada_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 3000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] chaves,
  input  logic       igual,
  input  logic       fim_e,
  output logic       zera_e,
  output logic       conta_e,
  output logic       zera_r,
  output logic       registra_r,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);
  estado_t estado_q, estado_d;
  logic [3:0] chaves_q, chaves_d;
  logic jogada, tmo, em_espera;
  assign em_espera = estado_q == ESPERA;
  assign chaves_d = chaves;
  assign jogada = (chaves != chaves_q) && (chaves != 4'h0);
  // counter is held clear outside ESPERA, so every wait starts from zero
  contador_timeout #(.M(TIMEOUT_CICLOS)) u_tmo (
    .clock(clock),
    .zera (reset | ~em_espera),
    .conta(em_espera),
    .fim  (tmo)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= INICIAL;
      chaves_q <= 4'h0;
    end else begin
      estado_q <= estado_d;
      chaves_q <= chaves_d;
    end
  end
  always_comb begin
    estado_d = INICIAL;
    case (estado_q)
      INICIAL:  estado_d = iniciar ? PREPARA : INICIAL;
      PREPARA:  estado_d = ESPERA;
      ESPERA:   estado_d = jogada ? REGISTRA : tmo ? FIM_TMO : ESPERA;
      REGISTRA: estado_d = COMPARA;
      COMPARA:  estado_d = !igual ? FIM_ERRO : fim_e ? FIM_OK : PROXIMO;
      PROXIMO:  estado_d = ESPERA;
      FIM_OK, FIM_ERRO, FIM_TMO: estado_d = iniciar ? PREPARA : estado_q;
      default:  estado_d = INICIAL;
    endcase
  end
  assign zera_e     = estado_q == PREPARA;
  assign zera_r     = estado_q == PREPARA;
  assign registra_r = estado_q == REGISTRA;
  assign conta_e    = estado_q == PROXIMO;
  assign acertou    = estado_q == FIM_OK;
  assign timeout    = estado_q == FIM_TMO;
  assign errou      = estado_q == FIM_ERRO || estado_q == FIM_TMO;
  assign pronto     = acertou || errou;
  assign db_estado  = estado_q;
endmodule

// File: tb/tb_unidade_controle_jogada.sv
// tb_unidade_controle_jogada: directed round scenarios plus random play against a reference model
module tb_unidade_controle_jogada;
  localparam int T = 10;
  logic clk = 0, rst = 0, iniciar = 0, igual = 0, fim_e = 0;
  logic [3:0] chaves = 0;
  logic zera_e, conta_e, zera_r, registra_r, pronto, acertou, errou, timeout;
  logic [3:0] db_estado;
  int total = 0, bad = 0;
  int ms = 0, mw = 0;
  logic [3:0] mp = 0;
  logic [7:0] exp_out [16];

  unidade_controle_jogada #(.TIMEOUT_CICLOS(T)) dut (
    .clock(clk), .reset(rst), .iniciar(iniciar), .chaves(chaves), .igual(igual), .fim_e(fim_e),
    .zera_e(zera_e), .conta_e(conta_e), .zera_r(zera_r), .registra_r(registra_r),
    .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout), .db_estado(db_estado)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // game rules evaluated on each rising edge, using plain integers for state and wait time
  task automatic model_step();
    int nxt;
    bit jog;
    if (rst) begin
      ms = 0; mp = 0; mw = 0;
      return;
    end
    jog = chaves != mp && chaves != 0;
    case (ms)
      0: nxt = iniciar ? 1 : 0;
      1: nxt = 2;
      2: nxt = jog ? 4 : (mw == T - 1 ? 'hD : 2);
      4: nxt = 5;
      5: nxt = !igual ? 'hE : (fim_e ? 'hA : 6);
      6: nxt = 2;
      'hA, 'hD, 'hE: nxt = iniciar ? 1 : ms;
      default: nxt = 0;
    endcase
    mw = (ms == 2 && nxt == 2) ? mw + 1 : 0;
    mp = chaves;
    ms = nxt;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("state_outs",
          {db_estado, zera_e, conta_e, zera_r, registra_r, pronto, acertou, errou, timeout},
          {ms[3:0], exp_out[ms[3:0]]});
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    // {zera_e, conta_e, zera_r, registra_r, pronto, acertou, errou, timeout} per state code
    foreach (exp_out[i]) exp_out[i] = 8'h00;
    exp_out[1] = 8'b1010_0000;
    exp_out[4] = 8'b0001_0000;
    exp_out[6] = 8'b0100_0000;
    exp_out[4'hA] = 8'b0000_1100;
    exp_out[4'hE] = 8'b0000_1010;
    exp_out[4'hD] = 8'b0000_1011;
    #2;
    rst = 1; cyc(); rst = 0;
    check("reset_state", {8'h0, db_estado}, 12'h000);
    iniciar = 1; cyc(); iniciar = 0;
    check("prepara", {8'h0, db_estado}, 12'h001);
    cyc();
    check("espera", {8'h0, db_estado}, 12'h002);
    igual = 1;
    for (int i = 0; i < 16; i++) begin
      chaves = (i % 2 == 0) ? 4'h1 : 4'h2;
      fim_e = i == 15;
      cycn(3);
      if (i < 15) cyc();
    end
    check("acertou", {8'h0, db_estado}, 12'h00A);
    fim_e = 0; chaves = 4'h2; iniciar = 1; cyc(); iniciar = 0; cyc();
    chaves = 4'h4; igual = 0; cycn(3);
    check("errou", {8'h0, db_estado}, 12'h00E);
    igual = 1; iniciar = 1; cyc(); iniciar = 0;
    check("restart", {8'h0, db_estado}, 12'h001);
    cycn(1 + T);
    check("timeout", {8'h0, db_estado}, 12'h00D);
    iniciar = 1; cyc(); iniciar = 0; cycn(1 + T - 1);
    chaves = 4'h8; cyc();
    check("move_beats_tmo", {8'h0, db_estado}, 12'h004);
    cyc(); rst = 1; cyc(); rst = 0;
    check("reset_midround", {8'h0, db_estado}, 12'h000);
    for (int n = 0; n < 4000; n++) begin
      rst = $urandom_range(0, 199) == 0;
      iniciar = $urandom_range(0, 7) == 0;
      if ($urandom_range(0, 3) == 0) chaves = 4'($urandom);
      igual = $urandom_range(0, 5) != 0;
      fim_e = $urandom_range(0, 4) == 0;
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
